// File: rtl/axi_fifo_pkg.sv
// rtl/axi_fifo_pkg.sv - shared types and register map for the AXI-Lite FIFO subordinate
//
// Purpose : response codes, register indices, CTRL bit positions and the
//           write/read channel FSM state types used by axi_lite_fifo_sub.
// Ports   : none (package).

package axi_fifo_pkg;

   // AXI response codes returned on B and R
   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   // Register indices, decoded from address bits [4:2]
   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd1;
   localparam logic [2:0] REG_TXDATA = 3'd2;
   localparam logic [2:0] REG_RXDATA = 3'd3;
   localparam logic [2:0] REG_IRQ    = 3'd4;

   // CTRL bit positions
   localparam int CTRL_FIFO_EN         = 0;
   localparam int CTRL_FLUSH           = 1;
   localparam int CTRL_IRQ_FULL_EN     = 2;
   localparam int CTRL_IRQ_NONEMPTY_EN = 3;

   // IRQ_STAT bit positions
   localparam int IRQ_FULL_SEEN     = 0;
   localparam int IRQ_NONEMPTY_SEEN = 1;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_t;

endpackage

// File: rtl/axi_lite_fifo_sub.sv
// rtl/axi_lite_fifo_sub.sv - AXI4-Lite subordinate mapping bus accesses onto FIFO push/pop strobes
//
// Purpose : accepts AW/W/AR, returns B/R with OKAY or SLVERR, and turns
//           TXDATA writes / RXDATA reads into one-cycle FIFO push/pop
//           strobes. Exposes CTRL (fifo_en, flush hint) and STATUS.
// Ports   : clk, rst                  - clock, synchronous active-high reset
//           aw*/w*/b*                 - AXI-Lite write address/data/response
//           ar*/r*                    - AXI-Lite read address/data
//           write_enable, write_data  - FIFO push strobe and data
//           read_enable, read_data    - FIFO pop strobe and FWFT head data
//           full, empty               - FIFO status flags
//           irq                       - interrupt (only with AXI_FIFO_SUB_IRQ_EN)
// Option  : define AXI_FIFO_SUB_IRQ_EN to add the irq output, CTRL bits [3:2]
//           and the W1C IRQ_STAT register at index 4.

module axi_lite_fifo_sub
   import axi_fifo_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wvalid,
   output logic              wready,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic [ADDR_W-1:0] araddr,
   input  logic              arvalid,
   output logic              arready,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        rresp,
   output logic              rvalid,
   input  logic              rready,
   output logic              write_enable,
   output logic [DATA_W-1:0] write_data,
   output logic              read_enable,
   input  logic [DATA_W-1:0] read_data,
   input  logic              full,
   input  logic              empty
`ifdef AXI_FIFO_SUB_IRQ_EN
   ,
   output logic              irq
`endif
);

   // ---------------- write channel state ----------------
   w_state_t          r_w_state;
   logic              r_awready;
   logic              r_wready;
   logic              r_aw_held;
   logic              r_w_held;
   logic [2:0]        r_aw_idx;
   logic [DATA_W-1:0] r_wdata;
   logic              r_bvalid;
   resp_t             r_bresp;
   logic              r_write_enable;
   logic [DATA_W-1:0] r_write_data;

   // ---------------- read channel state ----------------
   r_state_t          r_r_state;
   logic              r_arready;
   logic              r_rvalid;
   resp_t             r_rresp;
   logic [DATA_W-1:0] r_rdata;
   logic              r_read_enable;

   // ---------------- control registers ----------------
   logic              r_fifo_en;
`ifdef AXI_FIFO_SUB_IRQ_EN
   logic              r_irq_full_en;
   logic              r_irq_nonempty_en;
   logic              r_full_seen;
   logic              r_nonempty_seen;
   logic              r_full_d;
   logic              r_empty_d;
   logic              r_irq;
`endif

   // ---------------- combinational decode ----------------
   logic              w_aw_hs;
   logic              w_w_hs;
   logic              w_ar_hs;
   logic              w_wr_fire;
   logic              w_flush;
   logic [2:0]        w_ar_idx;
   resp_t             w_wr_resp;
   logic              w_wr_push;
   resp_t             w_rd_resp;
   logic              w_rd_pop;
   logic [DATA_W-1:0] w_rd_data;

   assign w_aw_hs  = awvalid & r_awready;
   assign w_w_hs   = wvalid  & r_wready;
   assign w_ar_hs  = arvalid & r_arready;
   assign w_ar_idx = araddr[4:2];

   // The write executes on the cycle both halves are held, never on the
   // handshake cycle itself, so a write always costs at least two cycles.
   assign w_wr_fire = (r_w_state == W_IDLE) & r_aw_held & r_w_held;

   // A flush request blocks any pop that would be decided in the same cycle.
   assign w_flush = w_wr_fire & (r_aw_idx == REG_CTRL) & r_wdata[CTRL_FLUSH];

   always_comb begin
      w_wr_resp = SLVERR;
      w_wr_push = 1'b0;
      case (r_aw_idx)
         REG_CTRL: begin
            w_wr_resp = OKAY;
         end
         REG_TXDATA: begin
            if (r_fifo_en && !full) begin
               w_wr_push = 1'b1;
               w_wr_resp = OKAY;
            end
         end
`ifdef AXI_FIFO_SUB_IRQ_EN
         REG_IRQ: begin
            w_wr_resp = OKAY;
         end
`endif
         default: begin
            w_wr_resp = SLVERR;
         end
      endcase
   end

   always_comb begin
      w_rd_data = '0;
      w_rd_resp = SLVERR;
      w_rd_pop  = 1'b0;
      case (w_ar_idx)
         REG_CTRL: begin
            w_rd_data[CTRL_FIFO_EN] = r_fifo_en;
`ifdef AXI_FIFO_SUB_IRQ_EN
            w_rd_data[CTRL_IRQ_FULL_EN]     = r_irq_full_en;
            w_rd_data[CTRL_IRQ_NONEMPTY_EN] = r_irq_nonempty_en;
`endif
            w_rd_resp = OKAY;
         end
         REG_STATUS: begin
            // Raw input flags: a push in flight this cycle is not yet visible.
            w_rd_data[1] = full;
            w_rd_data[0] = empty;
            w_rd_resp    = OKAY;
         end
         REG_RXDATA: begin
            if (r_fifo_en && !empty && !w_flush) begin
               w_rd_data = read_data;
               w_rd_pop  = 1'b1;
               w_rd_resp = OKAY;
            end
         end
`ifdef AXI_FIFO_SUB_IRQ_EN
         REG_IRQ: begin
            w_rd_data[IRQ_FULL_SEEN]     = r_full_seen;
            w_rd_data[IRQ_NONEMPTY_SEEN] = r_nonempty_seen;
            w_rd_resp = OKAY;
         end
`endif
         default: begin
            w_rd_resp = SLVERR;
         end
      endcase
   end

   // ---------------- write FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_w_state      <= W_IDLE;
         r_awready      <= 1'b0;
         r_wready       <= 1'b0;
         r_aw_held      <= 1'b0;
         r_w_held       <= 1'b0;
         r_aw_idx       <= '0;
         r_wdata        <= '0;
         r_bvalid       <= 1'b0;
         r_bresp        <= OKAY;
         r_write_enable <= 1'b0;
         r_write_data   <= '0;
      end else begin
         r_write_enable <= 1'b0;
         case (r_w_state)
            W_IDLE: begin
               if (w_wr_fire) begin
                  r_aw_held      <= 1'b0;
                  r_w_held       <= 1'b0;
                  r_bvalid       <= 1'b1;
                  r_bresp        <= w_wr_resp;
                  r_write_enable <= w_wr_push;
                  if (w_wr_push) begin
                     r_write_data <= r_wdata;
                  end
                  r_w_state      <= W_RESP;
               end else begin
                  if (w_aw_hs) begin
                     r_aw_idx  <= awaddr[4:2];
                     r_aw_held <= 1'b1;
                  end
                  if (w_w_hs) begin
                     r_wdata  <= wdata;
                     r_w_held <= 1'b1;
                  end
                  // Each channel drops its ready once its half is captured.
                  r_awready <= ~(r_aw_held | w_aw_hs);
                  r_wready  <= ~(r_w_held  | w_w_hs);
               end
            end
            W_RESP: begin
               if (bready) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
                  r_w_state <= W_IDLE;
               end
            end
            default: begin
               r_w_state <= W_IDLE;
            end
         endcase
      end
   end

   // ---------------- read FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_r_state     <= R_IDLE;
         r_arready     <= 1'b0;
         r_rvalid      <= 1'b0;
         r_rresp       <= OKAY;
         r_rdata       <= '0;
         r_read_enable <= 1'b0;
      end else begin
         r_read_enable <= 1'b0;
         case (r_r_state)
            R_IDLE: begin
               if (w_ar_hs) begin
                  // Head data is captured in the same cycle the pop is issued.
                  r_rdata       <= w_rd_data;
                  r_rresp       <= w_rd_resp;
                  r_read_enable <= w_rd_pop;
                  r_rvalid      <= 1'b1;
                  r_arready     <= 1'b0;
                  r_r_state     <= R_DATA;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (rready) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_r_state <= R_IDLE;
               end
            end
            default: begin
               r_r_state <= R_IDLE;
            end
         endcase
      end
   end

   // ---------------- CTRL register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fifo_en <= 1'b0;
`ifdef AXI_FIFO_SUB_IRQ_EN
         r_irq_full_en     <= 1'b0;
         r_irq_nonempty_en <= 1'b0;
`endif
      end else if (w_wr_fire && (r_aw_idx == REG_CTRL)) begin
         // The flush bit is a one-shot hint and is never stored.
         r_fifo_en <= r_wdata[CTRL_FIFO_EN];
`ifdef AXI_FIFO_SUB_IRQ_EN
         r_irq_full_en     <= r_wdata[CTRL_IRQ_FULL_EN];
         r_irq_nonempty_en <= r_wdata[CTRL_IRQ_NONEMPTY_EN];
`endif
      end
   end

`ifdef AXI_FIFO_SUB_IRQ_EN
   // ---------------- interrupt status ----------------
   logic       w_full_rise;
   logic       w_empty_fall;
   logic [1:0] w_irq_clr;

   assign w_full_rise  = full & ~r_full_d;
   assign w_empty_fall = ~empty & r_empty_d;
   assign w_irq_clr    = (w_wr_fire && (r_aw_idx == REG_IRQ)) ? r_wdata[1:0] : 2'b00;

   always_ff @(posedge clk) begin
      if (rst) begin
         // Edge history loads the live flags so reset never fakes an edge.
         r_full_d        <= full;
         r_empty_d       <= empty;
         r_full_seen     <= 1'b0;
         r_nonempty_seen <= 1'b0;
         r_irq           <= 1'b0;
      end else begin
         r_full_d        <= full;
         r_empty_d       <= empty;
         // A new edge wins over a simultaneous W1C.
         r_full_seen     <= w_full_rise  | (r_full_seen     & ~w_irq_clr[IRQ_FULL_SEEN]);
         r_nonempty_seen <= w_empty_fall | (r_nonempty_seen & ~w_irq_clr[IRQ_NONEMPTY_SEEN]);
         r_irq           <= (r_full_seen & r_irq_full_en) | (r_nonempty_seen & r_irq_nonempty_en);
      end
   end

   assign irq = r_irq;
`endif

   // Address bits outside [4:2] are intentionally ignored.
   logic w_unused;
   assign w_unused = &{1'b0, awaddr[ADDR_W-1:5], awaddr[1:0], araddr[ADDR_W-1:5], araddr[1:0]};

   assign awready      = r_awready;
   assign wready       = r_wready;
   assign bvalid       = r_bvalid;
   assign bresp        = r_bresp;
   assign arready      = r_arready;
   assign rvalid       = r_rvalid;
   assign rresp        = r_rresp;
   assign rdata        = r_rdata;
   assign write_enable = r_write_enable;
   assign write_data   = r_write_data;
   assign read_enable  = r_read_enable;

endmodule

// File: tb/tb_axi_lite_fifo_sub.sv
// tb/tb_axi_lite_fifo_sub.sv - scoreboard bench for axi_lite_fifo_sub

module tb_axi_lite_fifo_sub;

   localparam int DEPTH = 128;
   localparam logic [7:0] A_CTRL   = 8'h00;
   localparam logic [7:0] A_STATUS = 8'h04;
   localparam logic [7:0] A_TX     = 8'h08;
   localparam logic [7:0] A_RX     = 8'h0C;
   localparam logic [7:0] A_BAD    = 8'h14;
   localparam logic [1:0] R_OK     = 2'b00;
   localparam logic [1:0] R_ERR    = 2'b10;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] awaddr, wdata, araddr, rdata, write_data, read_data;
   logic       awvalid, awready, wvalid, wready, bvalid, bready;
   logic       arvalid, arready, rvalid, rready;
   logic [1:0] bresp, rresp;
   logic       write_enable, read_enable, full, empty;

   always #5 clk = ~clk;

   axi_lite_fifo_sub #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .write_enable(write_enable), .write_data(write_data),
      .read_enable(read_enable), .read_data(read_data),
      .full(full), .empty(empty)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // scoreboard queues
   logic [1:0] exp_b_q[$];
   logic [1:0] exp_rr_q[$];
   logic [7:0] exp_rd_q[$];
   logic [7:0] exp_fifo[$];

   // external FIFO stand-in (FWFT)
   logic [7:0] fifo_q[$];
   logic       m_full  = 1'b0;
   logic       m_empty = 1'b1;
   logic [7:0] m_head  = 8'h00;
   logic       force_full  = 1'b0;
   logic       force_empty = 1'b0;

   assign full      = force_full  | m_full;
   assign empty     = force_empty | m_empty;
   assign read_data = m_head;

   always @(posedge clk) begin
      if (read_enable && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (write_enable) fifo_q.push_back(write_data);
      m_full  <= (fifo_q.size() >= DEPTH);
      m_empty <= (fifo_q.size() == 0);
      m_head  <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
   end

   // strobe observation
   logic [7:0] wr_log[$];
   int rd_cnt   = 0;
   int both_cnt = 0;

   always @(negedge clk) begin
      if (write_enable) wr_log.push_back(write_data);
      if (read_enable) rd_cnt++;
      if (write_enable && read_enable) both_cnt++;
   end

   task automatic do_write(input logic [7:0] addr, input logic [7:0] data,
                           input int w_lead, input int b_hold);
      int c;
      bit aw_done, w_done;
      logic aw_hs, w_hs;
      logic [1:0] exp, first;
      exp = exp_b_q.pop_front();
      aw_done = 0; w_done = 0; c = 0;
      awaddr = addr; wdata = data; wvalid = 1'b1; awvalid = (w_lead == 0);
      while (!(aw_done && w_done) && c < 100) begin
         aw_hs = awvalid & awready;
         w_hs  = wvalid & wready;
         @(posedge clk); #1; c++;
         if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
         if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
         if (!aw_done && c >= w_lead) awvalid = 1'b1;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      c = 0;
      while (!bvalid && c < 100) begin @(posedge clk); #1; c++; end
      n_cmp++;
      if (bvalid !== 1'b1) begin
         $display("FAIL write_timeout addr=%h: bvalid=%b required 1", addr, bvalid);
         n_bad++;
         return;
      end
      first = bresp;
      for (int i = 0; i < b_hold; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (bvalid !== 1'b1 || bresp !== first) begin
            $display("FAIL b_hold cycle %0d: bvalid=%b bresp=%b required 1/%b", i, bvalid, bresp, first);
            n_bad++;
         end
      end
      n_cmp++;
      if (bresp !== exp) begin
         $display("FAIL bresp addr=%h: got %b required %b", addr, bresp, exp);
         n_bad++;
      end
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] addr);
      int c;
      bit done;
      logic hs;
      logic [7:0] exp_d;
      logic [1:0] exp_r;
      exp_d = exp_rd_q.pop_front();
      exp_r = exp_rr_q.pop_front();
      araddr = addr; arvalid = 1'b1; c = 0; done = 0;
      while (!done && c < 100) begin
         hs = arvalid & arready;
         @(posedge clk); #1; c++;
         if (hs) begin arvalid = 1'b0; done = 1; end
      end
      arvalid = 1'b0;
      c = 0;
      while (!rvalid && c < 100) begin @(posedge clk); #1; c++; end
      n_cmp++;
      if (rvalid !== 1'b1) begin
         $display("FAIL read_timeout addr=%h: rvalid=%b required 1", addr, rvalid);
         n_bad++;
         return;
      end
      n_cmp++;
      if (rdata !== exp_d) begin
         $display("FAIL rdata addr=%h: got %h required %h", addr, rdata, exp_d);
         n_bad++;
      end
      n_cmp++;
      if (rresp !== exp_r) begin
         $display("FAIL rresp addr=%h: got %b required %b", addr, rresp, exp_r);
         n_bad++;
      end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data, input logic [1:0] resp,
                     input int w_lead = 0, input int b_hold = 0);
      exp_b_q.push_back(resp);
      if (addr == A_TX && resp == R_OK) exp_fifo.push_back(data);
      do_write(addr, data, w_lead, b_hold);
   endtask

   task automatic rd(input logic [7:0] addr, input logic [7:0] exp_d, input logic [1:0] resp);
      exp_rd_q.push_back(exp_d);
      exp_rr_q.push_back(resp);
      do_read(addr);
   endtask

   task automatic rd_rx();
      logic [7:0] e;
      e = (exp_fifo.size() > 0) ? exp_fifo.pop_front() : 8'h00;
      rd(A_RX, e, R_OK);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      awaddr = 0; wdata = 0; araddr = 0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
         $display("FAIL reset_handshake: got %b required 00000", {awready, wready, arready, bvalid, rvalid});
         n_bad++;
      end
      n_cmp++;
      if ({bresp, rresp, rdata} !== 12'h000) begin
         $display("FAIL reset_resp_data: got %h required 000", {bresp, rresp, rdata});
         n_bad++;
      end
      n_cmp++;
      if ({write_enable, read_enable, write_data} !== 10'h000) begin
         $display("FAIL reset_strobes: got %h required 000", {write_enable, read_enable, write_data});
         n_bad++;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({awready, wready, arready} !== 3'b111) begin
         $display("FAIL ready_after_reset: got %b required 111", {awready, wready, arready});
         n_bad++;
      end
   endtask

   task automatic test_ctrl_status();
      wr(A_CTRL, 8'h01, R_OK);
      rd(A_CTRL, 8'h01, R_OK);
      rd(A_STATUS, 8'h01, R_OK);
      rd(A_BAD, 8'h00, R_ERR);
      wr(A_BAD, 8'hFF, R_ERR);
`ifndef AXI_FIFO_SUB_IRQ_EN
      rd(8'h10, 8'h00, R_ERR);
`endif
      rd(A_CTRL, 8'h01, R_OK);
   endtask

   task automatic test_push_pop();
      int wb, rb;
      wb = wr_log.size(); rb = rd_cnt;
      wr(A_TX, 8'hA5, R_OK);
      n_cmp++;
      if (wr_log.size() != wb + 1 || wr_log[wr_log.size() - 1] !== 8'hA5) begin
         $display("FAIL push_once: pushes=%0d last=%h required 1/a5", wr_log.size() - wb,
                  (wr_log.size() > 0) ? wr_log[wr_log.size() - 1] : 8'h00);
         n_bad++;
      end
      rd(A_STATUS, 8'h00, R_OK);
      rd_rx();
      n_cmp++;
      if (rd_cnt != rb + 1) begin
         $display("FAIL pop_once: pops=%0d required 1", rd_cnt - rb);
         n_bad++;
      end
   endtask

   task automatic test_full_empty();
      int wb, rb;
      wb = wr_log.size(); rb = rd_cnt;
      force_full = 1'b1;
      wr(A_TX, 8'h3C, R_ERR);
      rd(A_STATUS, 8'h03, R_OK);
      force_full = 1'b0;
      n_cmp++;
      if (wr_log.size() != wb) begin
         $display("FAIL push_when_full: pushes=%0d required 0", wr_log.size() - wb);
         n_bad++;
      end
      force_empty = 1'b1;
      rd(A_RX, 8'h00, R_ERR);
      force_empty = 1'b0;
      n_cmp++;
      if (rd_cnt != rb) begin
         $display("FAIL pop_when_empty: pops=%0d required 0", rd_cnt - rb);
         n_bad++;
      end
   endtask

   task automatic test_w_before_aw();
      int wb;
      wb = wr_log.size();
      wr(A_TX, 8'h5A, R_OK, 2, 5);
      n_cmp++;
      if (wr_log.size() != wb + 1) begin
         $display("FAIL w_lead_push: pushes=%0d required 1", wr_log.size() - wb);
         n_bad++;
      end
      rd_rx();
   endtask

   task automatic test_concurrent();
      int bb;
      wr(A_TX, 8'h11, R_OK);
      repeat (2) @(posedge clk);
      #1;
      bb = both_cnt;
      fork
         wr(A_TX, 8'h22, R_OK);
         begin
            @(posedge clk); #1;
            rd_rx();
         end
      join
      n_cmp++;
      if (both_cnt != bb + 1) begin
         $display("FAIL push_pop_same_cycle: coincident=%0d required 1", both_cnt - bb);
         n_bad++;
      end
      rd_rx();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 70; i++) wr(A_TX, 8'($urandom_range(0, 255)), R_OK);
      for (int i = 0; i < 70; i++) rd_rx();
      rd(A_STATUS, 8'h01, R_OK);
   endtask

   task automatic test_reset_mid();
      awaddr = A_CTRL; wdata = 8'h01; awvalid = 1'b1; wvalid = 1'b1;
      araddr = A_STATUS; arvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({bvalid, rvalid} !== 2'b11) begin
         $display("FAIL mid_valids_before: got %b required 11", {bvalid, rvalid});
         n_bad++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({bvalid, rvalid, write_enable, read_enable} !== 4'b0) begin
         $display("FAIL mid_reset_clear: got %b required 0000", {bvalid, rvalid, write_enable, read_enable});
         n_bad++;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      rd(A_CTRL, 8'h00, R_OK);
      wr(A_TX, 8'h77, R_ERR);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_ctrl_status();
      test_push_pop();
      test_full_empty();
      test_w_before_aw();
      test_concurrent();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axi_lite_fifo_sub.md
Name: axi_lite_fifo_sub

Overview:
AXI4-Lite subordinate (responder) that sits between the AXI manager bus agent and the FIFO's write/read port pair. It decodes bus writes and reads into single-cycle FIFO push/pop strobes and exposes control and status registers. It is the bus-side counterpart of the manager: it accepts AW/W/AR, and returns B/R with OKAY or SLVERR.

Parameters:
ADDR_W, 8, AXI address width; only bits [4:2] are decoded.
DATA_W, 8, AXI data width; also the FIFO data width.

Ports:
clk  in  1  single system clock.
rst  in  1  reset; synchronous, active-high.
awaddr  in  ADDR_W  write address.
awvalid  in  1  write address valid.
awready  out  1  write address ready.
wdata  in  DATA_W  write data.
wvalid  in  1  write data valid.
wready  out  1  write data ready.
bresp  out  2  write response.
bvalid  out  1  write response valid.
bready  in  1  write response ready.
araddr  in  ADDR_W  read address.
arvalid  in  1  read address valid.
arready  out  1  read address ready.
rdata  out  DATA_W  read data.
rresp  out  2  read response.
rvalid  out  1  read data valid.
rready  in  1  read data ready.
write_enable  out  1  FIFO push strobe, one cycle wide.
write_data  out  DATA_W  FIFO push data.
read_enable  out  1  FIFO pop strobe, one cycle wide.
read_data  in  DATA_W  FIFO head data; first-word-fall-through, valid while empty is low.
full  in  1  FIFO full.
empty  in  1  FIFO empty.

Behaviour:
- Reset values: all ready/valid outputs 0; bresp, rresp, and rdata 0; write_enable and read_enable 0; write_data 0; CTRL 0.
- Register map (addr[4:2]):
  - 0 CTRL (rw): bit0 fifo_en. bit1 flush_req, which always reads 0.
  - 1 STATUS (ro): {6'b0, full, empty}.
  - 2 TXDATA (wo): push.
  - 3 RXDATA (ro): pop.
  - Any other address: SLVERR, no side effects.
- Write FSM, states W_IDLE -> W_RESP -> W_IDLE:
  - In W_IDLE, awready and wready are high.
  - AW and W are each latched independently; the first one to arrive is held with its ready dropped.
  - On the cycle both are held, the write is performed, bvalid is set the next cycle, and the FSM enters W_RESP.
  - bvalid holds until bready; the FSM then returns to W_IDLE. Minimum 2 cycles per write.
- TXDATA write:
  - fifo_en=1 and full=0: write_enable=1 for exactly one cycle with write_data=wdata; bresp=OKAY.
  - Otherwise: no push; bresp=SLVERR (2'b10).
- CTRL write with bit1 set: asserts both write_enable and read_enable low, and holds off pops for that cycle (flush is a hint; this block issues no strobes on that write). bit1 is not stored.
- Read FSM, states R_IDLE -> R_DATA -> R_IDLE:
  - arready is high in R_IDLE.
  - On an AR handshake, rdata/rresp are registered and rvalid goes high the next cycle.
  - rvalid holds until rready.
- RXDATA read:
  - fifo_en=1 and empty=0: rdata=read_data is captured at the handshake, read_enable pulses for exactly one cycle in the same cycle as the capture, rresp=OKAY.
  - Otherwise: rdata=0, rresp=SLVERR, no pop.
- Read/write channels are independent. A push and a pop in the same cycle are legal and both are issued. A STATUS read coincident with a push reports the pre-push flags.
- rdata and bresp are stable while their valid is high and ready is low.
- Reset mid-transaction: any pending response is discarded and both FSMs return to IDLE. A strobe already asserted is dropped in the next cycle.

Optional Feature:
AXI_FIFO_SUB_IRQ_EN:
- Defined:
  - Adds output irq (1 bit, reset 0).
  - CTRL bit2 = irq_full_en, bit3 = irq_nonempty_en.
  - New register 4 IRQ_STAT: bit0 full_seen and bit1 nonempty_seen are sticky on the rising edge of full or the falling edge of empty, and cleared by writing 1 (W1C).
  - irq = |(IRQ_STAT & enables), registered, one cycle after the flag sets.
- Undefined: no irq port; address 4 returns SLVERR; CTRL bits [3:2] read 0.

Decomposition:
- Package axi_fifo_pkg holds:
  - resp_t enum: OKAY=2'b00, SLVERR=2'b10.
  - Register index constants REG_CTRL, REG_STATUS, REG_TXDATA, REG_RXDATA, REG_IRQ.
  - CTRL bit positions.
  - w_state_t and r_state_t enums.
- No sub-module is needed. An optional axi_fifo_sub_regs may hold CTRL/IRQ_STAT storage, but the block stays flat by default.

Test Plan:
- Reset, then write CTRL=8'h01, then read CTRL -> rdata=8'h01, rresp=OKAY. Read STATUS with FIFO empty -> 8'h01.
- With fifo_en=1, write TXDATA 8'hA5 -> exactly one write_enable pulse with write_data=8'hA5 and bresp=OKAY. Then read RXDATA -> rdata=8'hA5, one read_enable pulse.
- Hold full=1 and write TXDATA 8'h3C -> no write_enable, bresp=SLVERR. Hold empty=1 and read RXDATA -> rdata=8'h00, rresp=SLVERR, no read_enable.
- Present W two cycles before AW, and hold bready=0 for 5 cycles -> single push; bvalid stays high with stable bresp until bready.
- Push and pop issued in the same cycle via concurrent AW/W and AR -> write_enable and read_enable are both high in that one cycle. Then 70 back-to-back writes and 70 reads return data in order.
- Assert rst while bvalid=1 and rvalid=1 -> all valids, strobes, and CTRL are 0 on the following cycle.
